// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM bank arbiter: priority state
// encoding and the bank-index width helper.
package dpram_pkg;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    localparam int unsigned CNT_W = 16;

    // Bank index width for a power-of-two bank count; NUM_BANKS must be >= 2.
    function automatic int unsigned bank_bits(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/dpram_bank_decode.sv
// Word address to bank index: the bank is selected by the top address bits.
module dpram_bank_decode
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_BANKS  = 4
) (
    input  logic [ADDR_WIDTH-1:0]             addr_i,
    output logic [bank_bits(NUM_BANKS)-1:0]   bank_o
);

    localparam int unsigned BANK_W = bank_bits(NUM_BANKS);

    assign bank_o = addr_i[ADDR_WIDTH-1 -: BANK_W];

endmodule

// File: rtl/dpram_bank_arbiter.sv
// Two-port front end for a banked dual-port RAM: same-bank requests are
// serialized with toggling priority, read responses return one cycle later.
module dpram_bank_arbiter
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_BANKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_a,
    output logic                  req_ready_a,
    input  logic                  req_we_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [DATA_WIDTH-1:0] req_wdata_a,
    output logic                  rsp_valid_a,
    output logic [DATA_WIDTH-1:0] rsp_rdata_a,

    input  logic                  req_valid_b,
    output logic                  req_ready_b,
    input  logic                  req_we_b,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [DATA_WIDTH-1:0] req_wdata_b,
    output logic                  rsp_valid_b,
    output logic [DATA_WIDTH-1:0] rsp_rdata_b,

    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,

    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b,

    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int unsigned BANK_W = bank_bits(NUM_BANKS);

    logic [BANK_W-1:0] bank_a;
    logic [BANK_W-1:0] bank_b;
    logic              conflict;
    logic              arb_a;
    logic              arb_b;
    pri_e              pri_q;
    pri_e              pri_d;
    logic              rsp_valid_a_q;
    logic              rsp_valid_a_d;
    logic              rsp_valid_b_q;
    logic              rsp_valid_b_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    dpram_bank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BANKS  (NUM_BANKS)
    ) u_decode_a (
        .addr_i (req_addr_a),
        .bank_o (bank_a)
    );

    dpram_bank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BANKS  (NUM_BANKS)
    ) u_decode_b (
        .addr_i (req_addr_b),
        .bank_o (bank_b)
    );

    assign conflict = req_valid_a && req_valid_b && (bank_a == bank_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Each resolved conflict hands priority to the port that just lost.
    always_comb begin
        pri_d = pri_q;
        if (conflict) begin
            pri_d = (pri_q == PRI_A) ? PRI_B : PRI_A;
        end
    end

    always_comb begin
        arb_a = req_valid_a && (!conflict || (pri_q == PRI_A));
        arb_b = req_valid_b && (!conflict || (pri_q == PRI_B));
    end

    // Reset gates only the outward grant; the response flops are held clear
    // by their async reset, so their next-state needs no reset term.
    assign req_ready_a = arb_a && !rst;
    assign req_ready_b = arb_b && !rst;
    assign ram_we_a    = req_ready_a && req_we_a;
    assign ram_we_b    = req_ready_b && req_we_b;
    assign ram_addr_a  = req_addr_a;
    assign ram_addr_b  = req_addr_b;
    assign ram_din_a   = req_wdata_a;
    assign ram_din_b   = req_wdata_b;

    always_comb begin
        rsp_valid_a_d = arb_a && !req_we_a;
        rsp_valid_b_d = arb_b && !req_we_b;
        cnt_d         = cnt_q;
        if (conflict && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_a_q <= 1'b0;
            rsp_valid_b_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            rsp_valid_a_q <= rsp_valid_a_d;
            rsp_valid_b_q <= rsp_valid_b_d;
            cnt_q         <= cnt_d;
        end
    end

    assign rsp_valid_a  = rsp_valid_a_q;
    assign rsp_valid_b  = rsp_valid_b_q;
    assign rsp_rdata_a  = ram_dout_a;
    assign rsp_rdata_b  = ram_dout_b;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dpram_bank_arbiter.sv
// Bench for dpram_bank_arbiter paired with a behavioural banked dual-port RAM
// (8-bit data, 6-bit address, 4 banks) and a transaction-level reference model.
module tb_dpram_bank_arbiter;

    localparam int unsigned DW        = 8;
    localparam int unsigned AW        = 6;
    localparam int unsigned NB        = 4;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned BANK_SPAN = DEPTH / NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_a, req_ready_a, req_we_a, rsp_valid_a;
    logic [AW-1:0] req_addr_a;
    logic [DW-1:0] req_wdata_a, rsp_rdata_a;
    logic          req_valid_b, req_ready_b, req_we_b, rsp_valid_b;
    logic [AW-1:0] req_addr_b;
    logic [DW-1:0] req_wdata_b, rsp_rdata_b;
    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
    logic [15:0]   conflict_cnt;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pri_b;
    int unsigned   m_cnt;

    // Behavioural RAM: read-first, registered read data on both ports
    logic [DW-1:0] ram [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
        if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
        ram_dout_a <= ram[ram_addr_a];
        ram_dout_b <= ram[ram_addr_b];
    end

    dpram_bank_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_BANKS  (NB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_a  (req_valid_a),
        .req_ready_a  (req_ready_a),
        .req_we_a     (req_we_a),
        .req_addr_a   (req_addr_a),
        .req_wdata_a  (req_wdata_a),
        .rsp_valid_a  (rsp_valid_a),
        .rsp_rdata_a  (rsp_rdata_a),
        .req_valid_b  (req_valid_b),
        .req_ready_b  (req_ready_b),
        .req_we_b     (req_we_b),
        .req_addr_b   (req_addr_b),
        .req_wdata_b  (req_wdata_b),
        .rsp_valid_b  (rsp_valid_b),
        .rsp_rdata_b  (rsp_rdata_b),
        .ram_we_a     (ram_we_a),
        .ram_addr_a   (ram_addr_a),
        .ram_din_a    (ram_din_a),
        .ram_dout_a   (ram_dout_a),
        .ram_we_b     (ram_we_b),
        .ram_addr_b   (ram_addr_b),
        .ram_din_b    (ram_din_b),
        .ram_dout_b   (ram_dout_b),
        .conflict_cnt (conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pri_b = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock of traffic: predicts grants from the arbitration rules, then
    // the response and conflict count visible after the edge.
    task automatic cycle(input logic va, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic vb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         output logic ga, output logic gb);
        bit            conf;
        bit            ea, eb;
        bit            xa, xb;
        logic [DW-1:0] rda, rdb;
        @(negedge clk);
        req_valid_a = va; req_we_a = wa; req_addr_a = aa; req_wdata_a = da;
        req_valid_b = vb; req_we_b = wb; req_addr_b = ab; req_wdata_b = db;
        #1;
        conf = va && vb && ((int'(aa) / BANK_SPAN) == (int'(ab) / BANK_SPAN));
        ea   = va && (!conf || !m_pri_b);
        eb   = vb && (!conf ||  m_pri_b);
        chk("ready_a", 32'(req_ready_a), 32'(ea));
        chk("ready_b", 32'(req_ready_b), 32'(eb));
        chk("ram_we_a", 32'(ram_we_a), 32'(ea && wa));
        chk("ram_we_b", 32'(ram_we_b), 32'(eb && wb));
        @(posedge clk);
        xa  = ea && !wa;
        xb  = eb && !wb;
        rda = m_mem[aa];
        rdb = m_mem[ab];
        if (ea && wa) m_mem[aa] = da;
        if (eb && wb) m_mem[ab] = db;
        if (conf) begin
            m_pri_b = !m_pri_b;
            if (m_cnt < 65535) m_cnt++;
        end
        #1;
        chk("rsp_valid_a", 32'(rsp_valid_a), 32'(xa));
        chk("rsp_valid_b", 32'(rsp_valid_b), 32'(xb));
        if (xa) chk("rsp_rdata_a", 32'(rsp_rdata_a), 32'(rda));
        if (xb) chk("rsp_rdata_b", 32'(rsp_rdata_b), 32'(rdb));
        chk("conflict_cnt", 32'(conflict_cnt), m_cnt);
        ga = ea;
        gb = eb;
    endtask

    // Holds each request until granted, with a bounded cycle budget.
    task automatic pair(input logic va, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic vb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic pa, pb, ga, gb;
        int   n;
        pa = va;
        pb = vb;
        n  = 0;
        while ((pa || pb) && (n < 8)) begin
            cycle(pa, wa, aa, da, pb, wb, ab, db, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
            n++;
        end
        chk("pair_done", 32'(pa || pb), 32'(0));
    endtask

    task automatic idle();
        logic ga, gb;
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
    endtask

    initial begin
        logic          ga, gb;
        logic          pa, pb, wa, wb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;

        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        model_reset();

        // Reset state with requests pending
        rst = 1'b1;
        req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 6'h00; req_wdata_a = 8'h11;
        req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 6'h10; req_wdata_b = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_a", 32'(req_ready_a), 32'(0));
        chk("rst_ready_b", 32'(req_ready_b), 32'(0));
        chk("rst_ram_we_a", 32'(ram_we_a), 32'(0));
        chk("rst_rsp_valid_b", 32'(rsp_valid_b), 32'(0));
        chk("rst_cnt", 32'(conflict_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;

        // Different banks: both issue together
        cycle(1'b1, 1'b1, 6'h00, 8'hA1, 1'b1, 1'b1, 6'h10, 8'hB2, ga, gb);
        cycle(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h10, 8'h00, ga, gb);
        idle();

        // Bank-2 write conflict: A first, then B
        pair(1'b1, 1'b1, 6'h24, 8'hCA, 1'b1, 1'b1, 6'h20, 8'hCB);
        // Bank-2 readback conflict: priority now with B
        pair(1'b1, 1'b0, 6'h24, 8'h00, 1'b1, 1'b0, 6'h20, 8'h00);
        idle();

        // Port B alone
        cycle(1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h31, 8'hD5, ga, gb);
        cycle(1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h31, 8'h00, ga, gb);
        idle();

        // Back-to-back reads on both ports, different banks
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 6'h24, 8'h00, 1'b1, 1'b0, 6'h31, 8'h00, ga, gb);
        end
        idle();

        // Randomized traffic; a request not granted is held unchanged
        pa = 1'b0; pb = 1'b0;
        wa = 1'b0; wb = 1'b0; aa = '0; ab = '0; da = '0; db = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa) begin
                pa = 1'($urandom_range(0, 1));
                wa = 1'($urandom);
                aa = AW'($urandom);
                da = DW'($urandom);
            end
            if (!pb) begin
                pb = 1'($urandom_range(0, 1));
                wb = 1'($urandom);
                ab = AW'($urandom);
                db = DW'($urandom);
            end
            cycle(pa, wa, aa, da, pb, wb, ab, db, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        idle();

        // Reset the cycle after a granted read, with count and priority nonzero
        pair(1'b1, 1'b0, 6'h01, 8'h00, 1'b1, 1'b0, 6'h02, 8'h00);
        @(negedge clk);
        req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 6'h10;
        req_valid_b = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_rsp_valid_a", 32'(rsp_valid_a), 32'(1));
        rst = 1'b1;
        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 6'h31; req_wdata_b = 8'hEE;
        #1;
        chk("rst_async_rsp_valid_a", 32'(rsp_valid_a), 32'(0));
        chk("rst_async_cnt", 32'(conflict_cnt), 32'(0));
        chk("rst_hold_ready_a", 32'(req_ready_a), 32'(0));
        chk("rst_hold_ram_we_b", 32'(ram_we_b), 32'(0));
        @(posedge clk);
        #1;
        chk("rst_hold_rsp_valid_a", 32'(rsp_valid_a), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        model_reset();
        idle();
        // Priority back at A: A wins the first post-reset conflict
        pair(1'b1, 1'b0, 6'h31, 8'h00, 1'b1, 1'b0, 6'h30, 8'h00);
        idle();

        // Saturation of the conflict counter
        for (int i = 0; i < 65540; i++) begin
            cycle(1'b1, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h05, 8'h00, ga, gb);
        end
        chk("cnt_saturated", 32'(conflict_cnt), 32'hFFFF);
        idle();
        chk("cnt_saturated_hold", 32'(conflict_cnt), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
